// File: rtl/arm_flag_unit.sv
// ARM N/Z/C/V status-flag register with condition-code evaluation.
// Commits ALU or MSR flag results on the clock edge and feeds C back as carry-in.
module arm_flag_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       flush,
  input  logic [3:0] cond,
  input  logic [3:0] alu_op,
  input  logic       s_bit,
  input  logic       alu_nf,
  input  logic       alu_zf,
  input  logic       alu_cf,
  input  logic       alu_vf,
  input  logic       sh_cout,
  input  logic       msr_we,
  input  logic [3:0] msr_flags,
  output logic       nf_q,
  output logic       zf_q,
  output logic       cf_q,
  output logic       vf_q,
  output logic       cin,
  output logic       cond_pass,
  output logic       flags_upd
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       upd_q;
  logic       upd_d;
  logic       is_logical_s;
  logic       is_compare_s;
  logic       gate_s;

  assign nf_q      = flags_q[3];
  assign zf_q      = flags_q[2];
  assign cf_q      = flags_q[1];
  assign vf_q      = flags_q[0];
  assign cin       = flags_q[1];
  assign flags_upd = upd_q;

  // Condition decode against the registered flags only (no forwarding of alu_*).
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = zf_q;
      4'b0001: cond_pass = ~zf_q;
      4'b0010: cond_pass = cf_q;
      4'b0011: cond_pass = ~cf_q;
      4'b0100: cond_pass = nf_q;
      4'b0101: cond_pass = ~nf_q;
      4'b0110: cond_pass = vf_q;
      4'b0111: cond_pass = ~vf_q;
      4'b1000: cond_pass = cf_q & ~zf_q;
      4'b1001: cond_pass = ~cf_q | zf_q;
      4'b1010: cond_pass = (nf_q == vf_q);
      4'b1011: cond_pass = (nf_q != vf_q);
      4'b1100: cond_pass = ~zf_q & (nf_q == vf_q);
      4'b1101: cond_pass = zf_q | (nf_q != vf_q);
      4'b1110: cond_pass = 1'b1;
      4'b1111: cond_pass = 1'b0;
      default: cond_pass = 1'b0;
    endcase
  end

  // Opcode class: logical ops take C from the shifter and keep V.
  always_comb begin
    is_logical_s = 1'b0;
    case (alu_op)
      4'b0000, 4'b0001, 4'b1000, 4'b1001,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: is_logical_s = 1'b1;
      default:                            is_logical_s = 1'b0;
    endcase
  end

  assign is_compare_s = (alu_op[3:2] == 2'b10);
  assign gate_s       = en & ~flush & cond_pass;

  // Next-state selection; MSR takes priority over an ALU commit in the same cycle.
  always_comb begin
    flags_d = flags_q;
    upd_d   = 1'b0;
    if (gate_s && msr_we) begin
      flags_d = msr_flags;
      upd_d   = 1'b1;
    end else if (gate_s && (s_bit || is_compare_s)) begin
      if (is_logical_s) begin
        flags_d = {alu_nf, alu_zf, sh_cout, flags_q[0]};
      end else begin
        flags_d = {alu_nf, alu_zf, alu_cf, alu_vf};
      end
      upd_d = 1'b1;
    end else begin
      flags_d = flags_q;
      upd_d   = 1'b0;
    end
  end

  // Flag register and update pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= RESET_FLAGS;
      upd_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      upd_q   <= upd_d;
    end
  end

endmodule

// File: tb/tb_arm_flag_unit.sv
// Scoreboard bench for arm_flag_unit: directed plan steps plus random traffic,
// checked against an ARM condition/flag-rule reference model.
module tb_arm_flag_unit;

  localparam logic [3:0] RST_FLAGS = 4'b0000;

  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic       flush;
    logic [3:0] cond;
    logic [3:0] op;
    logic       s;
    logic [3:0] alu;
    logic       sh;
    logic       mw;
    logic [3:0] mf;
  } stim_t;

  typedef struct packed {
    logic       cp;
    logic [3:0] flags;
    logic       upd;
  } exp_t;

  logic clk, rst_n, en, flush, s_bit, alu_nf, alu_zf, alu_cf, alu_vf, sh_cout, msr_we;
  logic [3:0] cond, alu_op, msr_flags;
  logic nf_q, zf_q, cf_q, vf_q, cin, cond_pass, flags_upd;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] m_flags = RST_FLAGS;
  logic       m_upd   = 1'b0;

  arm_flag_unit #(.RESET_FLAGS(RST_FLAGS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .cond(cond), .alu_op(alu_op),
    .s_bit(s_bit), .alu_nf(alu_nf), .alu_zf(alu_zf), .alu_cf(alu_cf), .alu_vf(alu_vf),
    .sh_cout(sh_cout), .msr_we(msr_we), .msr_flags(msr_flags),
    .nf_q(nf_q), .zf_q(zf_q), .cf_q(cf_q), .vf_q(vf_q), .cin(cin),
    .cond_pass(cond_pass), .flags_upd(flags_upd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ARM condition evaluation: even codes test a predicate, odd codes its inverse.
  function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return !c[0];
    return base ^ c[0];
  endfunction

  task automatic step(input stim_t st);
    logic cp, gate;
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = st.rst_n; en = st.en; flush = st.flush; cond = st.cond; alu_op = st.op;
    s_bit = st.s; {alu_nf, alu_zf, alu_cf, alu_vf} = st.alu; sh_cout = st.sh;
    msr_we = st.mw; msr_flags = st.mf;
    if (!st.rst_n) begin
      m_flags = RST_FLAGS;
      m_upd   = 1'b0;
    end
    cp = ref_cond(m_flags, st.cond);
    e.cp = cp; e.flags = m_flags; e.upd = m_upd;
    sb.push_back(e);
    gate = st.rst_n && st.en && !st.flush && cp;
    m_upd = 1'b0;
    if (gate && st.mw) begin
      m_flags = st.mf;
      m_upd   = 1'b1;
    end else if (gate && (st.s || st.op inside {4'd8, 4'd9, 4'd10, 4'd11})) begin
      if (st.op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11})
        m_flags = st.alu;
      else
        m_flags = {st.alu[3], st.alu[2], st.sh, m_flags[0]};
      m_upd = 1'b1;
    end
  endtask

  function automatic stim_t idle();
    stim_t st;
    st = '0;
    st.rst_n = 1'b1;
    st.cond  = 4'b1110;
    return st;
  endfunction

  function automatic stim_t rnd();
    stim_t st;
    st.rst_n = 1'b1;
    st.en    = ($urandom_range(0, 9) != 0);
    st.flush = ($urandom_range(0, 7) == 0);
    st.cond  = 4'($urandom_range(0, 15));
    st.op    = 4'($urandom_range(0, 15));
    st.s     = 1'($urandom_range(0, 1));
    st.alu   = 4'($urandom_range(0, 15));
    st.sh    = 1'($urandom_range(0, 1));
    st.mw    = ($urandom_range(0, 5) == 0);
    st.mf    = 4'($urandom_range(0, 15));
    return st;
  endfunction

  task automatic msr(input logic [3:0] f);
    stim_t st;
    st = idle();
    st.en = 1'b1; st.mw = 1'b1; st.mf = f;
    step(st);
  endtask

  task automatic alu(input logic [3:0] c, input logic [3:0] op, input logic s,
                     input logic [3:0] a, input logic sh, input logic fl);
    stim_t st;
    st = idle();
    st.en = 1'b1; st.flush = fl; st.cond = c; st.op = op; st.s = s; st.alu = a; st.sh = sh;
    step(st);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents cond_pass and the flag state; pop and compare.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cond_pass", {3'b000, cond_pass}, {3'b000, e.cp});
      chk("flags", {nf_q, zf_q, cf_q, vf_q}, e.flags);
      chk("flags_upd", {3'b000, flags_upd}, {3'b000, e.upd});
      chk("cin", {3'b000, cin}, {3'b000, e.flags[1]});
    end
  end

  initial begin
    stim_t st;
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; cond = 4'b0000; alu_op = 4'b0000; s_bit = 1'b0;
    alu_nf = 1'b0; alu_zf = 1'b0; alu_cf = 1'b0; alu_vf = 1'b0; sh_cout = 1'b0;
    msr_we = 1'b0; msr_flags = 4'b0000;
    st = idle(); st.rst_n = 1'b0;
    step(st);
    step(idle());

    // Reset mid-cycle with flags 1111, then hold en=0 with random inputs.
    msr(4'b1111);
    step(idle());
    st = rnd(); st.rst_n = 1'b0;
    step(st);
    for (int i = 0; i < 5; i++) begin
      st = rnd(); st.en = 1'b0;
      step(st);
    end

    // Condition table: every NZCV combination against every condition code.
    for (int f = 0; f < 16; f++) begin
      msr(4'(f));
      for (int c = 0; c < 16; c++) begin
        st = rnd(); st.en = 1'b0; st.cond = 4'(c);
        step(st);
      end
    end

    // ADDS then the same without S.
    msr(4'b0000);
    alu(4'b1110, 4'b0100, 1'b1, 4'b0011, 1'b0, 1'b0);
    alu(4'b1110, 4'b0100, 1'b0, 4'b1100, 1'b0, 1'b0);
    step(idle());

    // ANDS keeps V; CMP without S still commits.
    msr(4'b0001);
    alu(4'b1110, 4'b0000, 1'b1, 4'b1100, 1'b1, 1'b0);
    alu(4'b1110, 4'b1010, 1'b0, 4'b0010, 1'b0, 1'b0);
    step(idle());

    // Failed condition and flush both suppress updates.
    msr(4'b0000);
    alu(4'b0000, 4'b1010, 1'b0, 4'b0100, 1'b0, 1'b0);
    alu(4'b1110, 4'b0100, 1'b1, 4'b1111, 1'b1, 1'b1);
    step(idle());

    // MSR and ADDS in the same cycle: MSR wins; then EQ fails.
    st = idle();
    st.en = 1'b1; st.mw = 1'b1; st.mf = 4'b1010; st.op = 4'b0100; st.s = 1'b1; st.alu = 4'b0101;
    step(st);
    st = idle(); st.cond = 4'b0000;
    step(st);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 1500; i++) begin
      st = rnd();
      if ($urandom_range(0, 199) == 0) st.rst_n = 1'b0;
      step(st);
    end
    step(idle());

    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_flag_unit.md
Name: arm_flag_unit

Overview:
- Architectural status-flag stage downstream of the ARM ALU.
- Holds the N/Z/C/V flags and evaluates each instruction's 4-bit condition field against them.
- Commits ALU flag results at the clock edge, following ARM rules per opcode class and S-bit. Accepts MSR flag writes.
- Feeds the registered carry back to the ALU as its carry-in.

Parameters:
- RESET_FLAGS, 4'b0000, reset value of {N,Z,C,V}.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance; no state change when 0.
- flush  in  1  current instruction squashed; blocks all updates.
- cond  in  4  condition field of the current instruction.
- alu_op  in  4  ALU opcode of the current instruction, in the ALU's encoding.
- s_bit  in  1  instruction S bit.
- alu_nf, alu_zf, alu_cf, alu_vf  in  1 each  ALU flag results for the current instruction.
- sh_cout  in  1  shifter carry-out; used as C for logical ops.
- msr_we  in  1  MSR flag-field write request.
- msr_flags  in  4  {N,Z,C,V} for MSR.
- nf_q, zf_q, cf_q, vf_q  out  1 each  registered flags.
- cin  out  1  equals cf_q; ALU carry-in.
- cond_pass  out  1  combinational: the current instruction's condition holds against the registered flags.
- flags_upd  out  1  registered pulse: flags changed source at the last edge (ALU or MSR commit).

Behaviour:
- Reset (async, rst_n=0):
  - {nf_q,zf_q,cf_q,vf_q} = RESET_FLAGS.
  - flags_upd = 0.
  - Takes effect immediately, including mid-instruction. The first edge after release behaves normally.
- cond_pass decode (N,Z,C,V = registered flags):
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V.
  - 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V).
  - 1110 1. 1111 0 (NV, never executes).
- Opcode classes:
  - Logical: 0000 AND, 0001 EOR, 1000 TST, 1001 TEQ, 1100 ORR, 1101 MOV, 1110 BIC, 1111 MVN.
  - Arithmetic: 0010 SUB, 0011 RSB, 0100 ADD, 0101 ADC, 0110 SBC, 0111 RSC, 1010 CMP, 1011 CMN.
  - Compare: alu_op[3:2]=2'b10 (TST, TEQ, CMP, CMN).
- Commit condition (ALU update): en & !flush & cond_pass & (s_bit | compare).
- ALU update values:
  - Arithmetic: N,Z,C,V <= alu_nf, alu_zf, alu_cf, alu_vf.
  - Logical: N <= alu_nf, Z <= alu_zf, C <= sh_cout, V unchanged.
- MSR update:
  - Applies when en & !flush & cond_pass & msr_we: all four flags <= msr_flags.
  - MSR and ALU update in the same cycle: MSR wins entirely.
- Stall: en=0 holds all flags. flags_upd <= 0.
- flush=1: no flag change. flags_upd <= 0.
- flags_upd <= 1 on the edge where any update commits (even if values are unchanged), else 0.
- Timing and forwarding:
  - Latency is one edge: the instruction after a flag-setter sees the new flags in cond_pass.
  - There is no same-cycle forwarding of alu_* into cond_pass.
- cin = cf_q, purely combinational from the register.
- Input handling: alu_* are taken as delivered; no inversion or reinterpretation of borrow.
- Implementation: one always block with async reset for the flag register; a combinational condition decoder.

Test Plan:
1. Reset and hold: assert rst_n=0 mid-cycle with flags 1111, RESET_FLAGS=0.
   -> Flags 0000 immediately. Hold en=0 for 5 cycles with random inputs -> flags stay 0000, flags_upd=0.
2. Condition table: preload flags via MSR to each of the 16 NZCV combos, sweep cond 0000..1111.
   -> cond_pass matches the table for all 256 pairs. Spot checks:
   - NZCV=1001, cond=1010 (GE) -> 1.
   - NZCV=0110, cond=1000 (HI) -> 0.
   - cond=1111 -> always 0.
3. ADD with S: cond=1110, alu_op=0100, s_bit=1, alu NZCV=0011.
   -> After edge flags=0011, cin=1, flags_upd=1 for one cycle.
   Same stimulus with s_bit=0 -> no change.
4. Logical with S: flags=0001, alu_op=0000 (AND), s_bit=1, alu NZCV=1100, alu_vf=0, sh_cout=1.
   -> Flags become N=1, Z=1, C=1, V=1 (V preserved). CMP (1010) with s_bit=0 still updates.
5. Conditional suppression: flags Z=0, cond=0000 (EQ), CMP with alu NZCV=0100 -> no update.
   flush=1 with cond=1110 and ADDS -> no update.
6. MSR/ALU collision: en=1, cond=1110, msr_we=1, msr_flags=1010, ADDS with alu NZCV=0101 in the same cycle.
   -> Flags=1010. Next cycle cond=0000 (EQ) -> cond_pass=0.
